multi_cycle_cpu: RTL and testbench
==================================

Name: multi_cycle_cpu

Overview:
Multi-cycle RV32I-subset CPU, the successor to the team's single-cycle core. One instruction executes over 3-5 clock cycles, sequenced by an FSM. Architectural registers (IR, A, B, ALUOUT, MDR) sit between phases. It instantiates the existing imem, regfile, alu and dmem blocks. It adds jal, halt on ecall or illegal opcode, and debug/performance outputs.

Parameters:
IMEM_DEPTH, 1024, imem entries (32-bit words)
IMEM_ADDR_WIDTH, 10, imem word-address width
REG_WIDTH, 32, datapath width
DMEM_DEPTH, 1024, dmem entries
DMEM_ADDR_WIDTH, 10, dmem word-address width
CNT_WIDTH, 32, width of the cycle and retired-instruction counters

Ports:
clk  input  1  system clock
reset_b  input  1  asynchronous active-low reset
halted  output  1  high while FSM is in HALT
illegal  output  1  sticky; set when HALT was entered via an unsupported opcode
dbg_pc  output  32  current PC register
dbg_state  output  3  FSM state encoding
retired  output  CNT_WIDTH  instructions completed
cycles  output  CNT_WIDTH  clock cycles since reset, frozen in HALT

Behaviour:
- Reset (reset_b=0, asynchronous): the following are all zeroed.
  - PC, IR, A, B, ALUOUT, MDR, retired, cycles, illegal and halted.
  - State goes to FETCH; dbg_pc=0, dbg_state=FETCH.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Only the architectural registers change per phase. regfile writes only in WB; dmem writes only in MEM.
- FETCH:
  - IR <= imem[PC[IMEM_ADDR_WIDTH+1:2]]; cycles increments.
  - Next state is DECODE.
- DECODE:
  - A <= rs1_dout, B <= rs2_dout (rs1=IR[19:15], rs2=IR[24:20]).
  - Immediate sign-extended per format: I, S, B (<<1), J (<<1).
  - opcode 1110011 (ecall) -> HALT.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111} -> HALT and illegal<=1.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: ALUOUT <= A op B, with funct3 111 and, 110 or, 100 xor, 000 add, or sub when funct7[5]=1. -> WB.
  - I-type: same ops with B replaced by the immediate; funct7 is ignored (no subi). -> WB.
  - lw/sw: ALUOUT <= A + imm. -> MEM.
  - Branch:
    - ALU computes A - B.
    - Taken when: beq on zero, bne on !zero, blt on sign, bge on !sign.
    - Taken: PC <= PC + immB. Not taken: PC <= PC + 4.
    - Unsupported branch funct3: PC <= PC + 4.
    - retired++, -> FETCH.
  - jal: ALUOUT <= PC + 4, PC <= PC + immJ. -> WB.
- MEM:
  - dmem addr = ALUOUT[DMEM_ADDR_WIDTH+1:2].
  - lw: MDR <= dmem_dout. -> WB.
  - sw: mem_write=1 for exactly this cycle, din=B, PC <= PC + 4, retired++. -> FETCH.
- WB:
  - regfile write of rd=IR[11:7] with MDR for lw, ALUOUT otherwise.
  - PC <= PC + 4, except jal, whose PC was already updated.
  - retired++, -> FETCH.
  - Writes to x0 are discarded; reading x0 returns 0.
- Latency (cycles per instruction): R/I 4, lw 5, sw 4, branch 3, jal 4, ecall/illegal 2 then halt.
- HALT: absorbing until reset.
  - No register or memory writes; PC holds the address of the halting instruction.
  - cycles and retired freeze.
- Arithmetic: PC and address adds wrap modulo 2^32. Counters wrap at 2^CNT_WIDTH without saturation.
- Address handling:
  - Addresses beyond DMEM_DEPTH alias via truncation.
  - Byte offset bits [1:0] are ignored (no misalignment trap).
- Reset mid-instruction: any partial instruction is abandoned.
  - A sw asserted in MEM at the reset edge does not complete.
  - No regfile write occurs after reset assertion.
- Branch/jal targets are not checked; an unaligned PC is truncated on fetch.

Test Plan:
- Reset/idle: hold reset_b=0 for 3 cycles, release -> dbg_pc=0, dbg_state=0, cycles=1 after first edge, retired=0.
- ALU sequence: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; xor x5,x1,x2; ecall -> x3=2, x4=8, x5=0xFFFFFFF8; retired=5, cycles=22, halted=1, illegal=0.
- Memory: addi x1,x0,0x40; sw x1,4(x1); lw x6,4(x1); ecall -> dmem word 0x11 = 0x40, x6=0x40, lw takes 5 cycles (check dbg_state 0,1,2,3,4).
- Branches:
  - x1=1, x2=2; blt x1,x2,+8 -> taken, PC advances by 8.
  - bge x1,x2,+8 -> not taken, PC advances by 4.
  - beq x0,x0,-4 -> PC decrements by 4.
  - Each branch costs 3 cycles.
- jal/x0: jal x7,+12 at PC=0x10 -> x7=0x14, PC=0x1C. Then addi x0,x0,9 -> x0 reads 0.
- Illegal/reset: opcode 0x7F at PC=0x8 -> halted=1, illegal=1, dbg_pc=0x8, counters frozen for 10 cycles. Asserting reset_b=0 during a sw MEM cycle -> the dmem word is unchanged.

Source files
------------

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: RV32I-subset core executing one instruction over 3-5 cycles.
// FSM phases FETCH/DECODE/EXEC/MEM/WB latch IR, A, B, ALUOUT and MDR between
// phases. Supports R/I ALU ops (add/sub/and/or/xor), lw, sw, beq/bne/blt/bge
// and jal. ecall halts cleanly; an unsupported opcode halts and sets illegal.
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   halted                high while the FSM sits in HALT
//   illegal               sticky, HALT was entered on an unsupported opcode
//   dbg_pc, dbg_state     current PC and FSM state encoding
//   retired, cycles       retired-instruction and non-halted cycle counters

// Instruction ROM, combinational read.
module imem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   dout
);
    logic [31:0] mem [DEPTH];
    assign dout = mem[addr];
endmodule

// 32 x W register file, two combinational reads, one synchronous write.
// x0 is never written and always reads as zero.
module regfile #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         we,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [4:0]   rd,
    input  logic [W-1:0] wd,
    output logic [W-1:0] rs1_dout,
    output logic [W-1:0] rs2_dout
);
    logic [W-1:0] regs [32];
    always_ff @(posedge clk) begin
        if (we && rd != 5'd0) regs[rd] <= wd;
    end
    assign rs1_dout = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_dout = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

// ALU keyed by funct3; sub only matters for funct3 000.
module alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   f3,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         zero
);
    always_comb begin
        case (f3)
            3'b111:  y = a & b;
            3'b110:  y = a | b;
            3'b100:  y = a ^ b;
            default: y = sub ? (a - b) : (a + b);
        endcase
    end
    assign zero = (y == '0);
endmodule

// Data RAM, combinational read, synchronous write.
module dmem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
    assign dout = mem[addr];
endmodule

module multi_cycle_cpu #(
    parameter int IMEM_DEPTH      = 1024,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset_b,
    output logic                 halted,
    output logic                 illegal,
    output logic [31:0]          dbg_pc,
    output logic [2:0]           dbg_state,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [CNT_WIDTH-1:0] cycles
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_ECALL = 7'b1110011;

    state_t state, state_nxt;
    logic [REG_WIDTH-1:0] pc, ir, a, b, aluout, mdr;
    logic [REG_WIDTH-1:0] imm_i, imm_s, imm_b, imm_j;
    logic [REG_WIDTH-1:0] alu_a, alu_b, alu_y, imem_dout, rs1_dout, rs2_dout, dmem_dout, wb_data;
    logic [2:0]           alu_f3;
    logic                 alu_sub, alu_zero, br_taken, legal, rf_we, mem_we;

    wire [6:0] opcode = ir[6:0];
    wire [2:0] funct3 = ir[14:12];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign legal = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    assign wb_data = (opcode == OP_LOAD) ? mdr : aluout;

    imem #(.DEPTH(IMEM_DEPTH), .AW(IMEM_ADDR_WIDTH)) u_imem (
        .addr(pc[IMEM_ADDR_WIDTH+1:2]), .dout(imem_dout));

    regfile #(.W(REG_WIDTH)) u_rf (
        .clk(clk), .we(rf_we), .rs1(ir[19:15]), .rs2(ir[24:20]), .rd(ir[11:7]),
        .wd(wb_data), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout));

    alu #(.W(REG_WIDTH)) u_alu (
        .a(alu_a), .b(alu_b), .f3(alu_f3), .sub(alu_sub), .y(alu_y), .zero(alu_zero));

    dmem #(.DEPTH(DMEM_DEPTH), .AW(DMEM_ADDR_WIDTH), .W(REG_WIDTH)) u_dmem (
        .clk(clk), .we(mem_we), .addr(aluout[DMEM_ADDR_WIDTH+1:2]), .din(b), .dout(dmem_dout));

    // ALU operand/op selection; only meaningful in EXEC.
    always_comb begin
        alu_a   = a;
        alu_b   = b;
        alu_f3  = 3'b000;
        alu_sub = 1'b0;
        case (opcode)
            OP_R:      begin alu_f3 = funct3; alu_sub = ir[30]; end
            OP_I:      begin alu_f3 = funct3; alu_b = imm_i; end
            OP_LOAD:   alu_b = imm_i;
            OP_STORE:  alu_b = imm_s;
            OP_BRANCH: alu_sub = 1'b1;
            OP_JAL:    begin alu_a = pc; alu_b = REG_WIDTH'(4); end
            default:   ;
        endcase
    end

    // Branch decision on A - B: blt/bge use the raw sign bit of the difference.
    always_comb begin
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_y[REG_WIDTH-1];
            3'b101:  br_taken = !alu_y[REG_WIDTH-1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                if (opcode == OP_ECALL || !legal) state_nxt = HALT;
                else                              state_nxt = EXEC;
            end
            EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEM;
                    OP_BRANCH:         state_nxt = FETCH;
                    default:           state_nxt = WB;
                endcase
            end
            MEM: begin
                if (opcode == OP_LOAD) state_nxt = WB;
                else begin
                    mem_we    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            WB: begin
                rf_we     = 1'b1;
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            aluout  <= '0;
            mdr     <= '0;
            retired <= '0;
            cycles  <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counts every cycle spent outside HALT, not just fetches.
            if (state != HALT) cycles <= cycles + CNT_WIDTH'(1);
            case (state)
                FETCH:  ir <= imem_dout;
                DECODE: begin
                    a <= rs1_dout;
                    b <= rs2_dout;
                    if (opcode != OP_ECALL && !legal) illegal <= 1'b1;
                end
                EXEC: begin
                    if (opcode == OP_BRANCH) begin
                        pc      <= br_taken ? (pc + imm_b) : (pc + REG_WIDTH'(4));
                        retired <= retired + CNT_WIDTH'(1);
                    end else begin
                        aluout <= alu_y;
                        // jal's link value is PC+4 from the ALU; PC jumps now.
                        if (opcode == OP_JAL) pc <= pc + imm_j;
                    end
                end
                MEM: begin
                    if (opcode == OP_LOAD) mdr <= dmem_dout;
                    else begin
                        pc      <= pc + REG_WIDTH'(4);
                        retired <= retired + CNT_WIDTH'(1);
                    end
                end
                WB: begin
                    if (opcode != OP_JAL) pc <= pc + REG_WIDTH'(4);
                    retired <= retired + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign halted    = (state == HALT);
    assign dbg_pc    = 32'(pc);
    assign dbg_state = state;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: each test loads a program while in
// reset and queues expectations; a negedge monitor compares reset state,
// the post-reset state, PC/cycles at every retirement and the final
// architectural state ten cycles into HALT.
module tb_multi_cycle_cpu;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        halted, illegal;
    logic [31:0] dbg_pc;
    logic [2:0]  dbg_state;
    logic [31:0] retired, cycles;

    multi_cycle_cpu u_dut (
        .clk(clk), .reset_b(reset_b), .halted(halted), .illegal(illegal),
        .dbg_pc(dbg_pc), .dbg_state(dbg_state), .retired(retired), .cycles(cycles));

    always #5 clk = ~clk;

    localparam int Q_RST = 0, Q_POST = 1, Q_HALT = 2;
    localparam int S_REG = 0, S_MEM = 1, S_PC = 2, S_ST = 3, S_RET = 4, S_CYC = 5, S_HLT = 6, S_ILL = 7;

    typedef struct { string name; int sel; int idx; logic [31:0] exp; } chk_t;
    typedef struct { logic [31:0] pc; logic [31:0] cyc; } ret_t;

    chk_t        rst_q[$], post_q[$], halt_q[$];
    ret_t        ret_q[$];
    logic [31:0] prog[$];
    int          total = 0, bad = 0;
    bit          halt_done = 1'b0;

    function automatic logic [31:0] peek(int sel, int idx);
        case (sel)
            S_REG:   return u_dut.u_rf.regs[idx];
            S_MEM:   return u_dut.u_dmem.mem[idx];
            S_PC:    return dbg_pc;
            S_ST:    return {29'b0, dbg_state};
            S_RET:   return retired;
            S_CYC:   return cycles;
            S_HLT:   return {31'b0, halted};
            default: return {31'b0, illegal};
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_item(chk_t c);
        cmp(c.name, peek(c.sel, c.idx), c.exp);
    endtask

    task automatic push(int q, string n, int sel, int idx, logic [31:0] e);
        chk_t c;
        c.name = n; c.sel = sel; c.idx = idx; c.exp = e;
        case (q)
            Q_RST:   rst_q.push_back(c);
            Q_POST:  post_q.push_back(c);
            default: halt_q.push_back(c);
        endcase
    endtask

    task automatic exp_ret(logic [31:0] p, logic [31:0] c);
        ret_t r;
        r.pc = p; r.cyc = c;
        ret_q.push_back(r);
    endtask

    // Monitor
    int          post_rst = 0, halt_cnt = 0;
    logic [31:0] prev_ret = '0;
    ret_t        mr;
    always @(negedge clk) begin
        if (!reset_b) begin
            post_rst = 0;
            halt_cnt = 0;
            prev_ret = '0;
            while (rst_q.size() > 0) check_item(rst_q.pop_front());
        end else begin
            post_rst++;
            if (post_rst == 1)
                while (post_q.size() > 0) check_item(post_q.pop_front());
            if (retired != prev_ret) begin
                prev_ret = retired;
                if (ret_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL retire: unexpected retirement retired=%0d pc=%h", retired, dbg_pc);
                end else begin
                    mr = ret_q.pop_front();
                    cmp("ret_pc", dbg_pc, mr.pc);
                    cmp("ret_cycles", cycles, mr.cyc);
                end
            end
            if (halted) halt_cnt++;
            else        halt_cnt = 0;
            if (halt_cnt == 10) begin
                while (halt_q.size() > 0) check_item(halt_q.pop_front());
                cmp("ret_q_empty", 32'(ret_q.size()), 32'd0);
                halt_done = 1'b1;
            end
        end
    end

    // Instruction encoders
    function automatic logic [31:0] r_ins(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_ins(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_ins(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_ins(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_ins(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;

    // Assert reset, queue reset-state checks, load prog into imem.
    task automatic begin_test();
        @(negedge clk);
        #2;
        reset_b = 1'b0;
        push(Q_RST, "rst_pc", S_PC, 0, 32'h0);
        push(Q_RST, "rst_state", S_ST, 0, 32'd0);
        push(Q_RST, "rst_retired", S_RET, 0, 32'd0);
        push(Q_RST, "rst_cycles", S_CYC, 0, 32'd0);
        push(Q_RST, "rst_halted", S_HLT, 0, 32'd0);
        push(Q_RST, "rst_illegal", S_ILL, 0, 32'd0);
        for (int i = 0; i < 1024; i++) u_dut.u_imem.mem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) u_dut.u_imem.mem[i] = prog[i];
        repeat (3) @(negedge clk);
    endtask

    task automatic run_to_halt(string name);
        halt_done = 1'b0;
        #2;
        reset_b = 1'b1;
        for (int i = 0; i < 500 && !halt_done; i++) @(negedge clk);
        if (!halt_done) begin
            total++; bad++;
            $display("FAIL %s_timeout: no halt within budget, pc=%h state=%0d", name, dbg_pc, dbg_state);
            halt_q.delete();
            ret_q.delete();
        end
    endtask

    task automatic exp_halt(logic [31:0] pc, logic [31:0] ret, logic [31:0] cyc, logic ill);
        push(Q_HALT, "halt_pc", S_PC, 0, pc);
        push(Q_HALT, "halt_state", S_ST, 0, 32'd5);
        push(Q_HALT, "halt_halted", S_HLT, 0, 32'd1);
        push(Q_HALT, "halt_illegal", S_ILL, 0, {31'b0, ill});
        push(Q_HALT, "halt_retired", S_RET, 0, ret);
        push(Q_HALT, "halt_cycles", S_CYC, 0, cyc);
    endtask

    initial begin
        // ALU sequence, plus post-reset state after the first edge
        prog.delete();
        prog.push_back(i_ins(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(i_ins(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13));
        prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        prog.push_back(r_ins(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
        prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'b100, 5'd5));
        prog.push_back(ECALL);
        begin_test();
        push(Q_POST, "post_pc", S_PC, 0, 32'h0);
        push(Q_POST, "post_state", S_ST, 0, 32'd1);
        push(Q_POST, "post_cycles", S_CYC, 0, 32'd1);
        push(Q_POST, "post_retired", S_RET, 0, 32'd0);
        exp_ret(32'h4, 4); exp_ret(32'h8, 8); exp_ret(32'hC, 12); exp_ret(32'h10, 16); exp_ret(32'h14, 20);
        push(Q_HALT, "alu_x1", S_REG, 1, 32'd5);
        push(Q_HALT, "alu_x2", S_REG, 2, 32'hFFFF_FFFD);
        push(Q_HALT, "alu_add_x3", S_REG, 3, 32'd2);
        push(Q_HALT, "alu_sub_x4", S_REG, 4, 32'd8);
        push(Q_HALT, "alu_xor_x5", S_REG, 5, 32'hFFFF_FFF8);
        exp_halt(32'h14, 5, 22, 1'b0);
        run_to_halt("alu");

        // Memory: sw then lw (lw costs 5 cycles)
        prog.delete();
        prog.push_back(i_ins(12'h040, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(s_ins(12'd4, 5'd1, 5'd1));
        prog.push_back(i_ins(12'd4, 5'd1, 3'b010, 5'd6, 7'h03));
        prog.push_back(ECALL);
        begin_test();
        exp_ret(32'h4, 4); exp_ret(32'h8, 8); exp_ret(32'hC, 13);
        push(Q_HALT, "mem_word11", S_MEM, 'h11, 32'h40);
        push(Q_HALT, "mem_lw_x6", S_REG, 6, 32'h40);
        exp_halt(32'hC, 3, 15, 1'b0);
        run_to_halt("mem");

        // Branches: bge not taken, blt taken +8, beq backward -4
        prog.delete();
        prog.push_back(i_ins(12'd1, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(i_ins(12'd2, 5'd0, 3'b000, 5'd2, 7'h13));
        prog.push_back(b_ins(13'd8, 5'd2, 5'd1, 3'b101));
        prog.push_back(b_ins(13'd8, 5'd2, 5'd1, 3'b100));
        prog.push_back(ECALL);
        prog.push_back(b_ins(13'h1FFC, 5'd0, 5'd0, 3'b000));
        begin_test();
        exp_ret(32'h4, 4); exp_ret(32'h8, 8); exp_ret(32'hC, 11); exp_ret(32'h14, 14); exp_ret(32'h10, 17);
        exp_halt(32'h10, 5, 19, 1'b0);
        run_to_halt("branch");

        // jal, I-type ops, x0 discard, funct7 ignored on addi
        prog.delete();
        prog.push_back(i_ins(12'd3, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(i_ins(12'd4, 5'd1, 3'b000, 5'd2, 7'h13));
        prog.push_back(i_ins(12'd5, 5'd2, 3'b111, 5'd3, 7'h13));
        prog.push_back(i_ins(12'd8, 5'd1, 3'b110, 5'd4, 7'h13));
        prog.push_back(j_ins(21'd12, 5'd7));
        prog.push_back(ECALL);
        prog.push_back(ECALL);
        prog.push_back(i_ins(12'd9, 5'd0, 3'b000, 5'd0, 7'h13));
        prog.push_back(i_ins(12'hFFF, 5'd1, 3'b100, 5'd5, 7'h13));
        prog.push_back(i_ins(12'h400, 5'd1, 3'b000, 5'd6, 7'h13));
        prog.push_back(r_ins(7'h00, 5'd1, 5'd0, 3'b000, 5'd8));
        prog.push_back(ECALL);
        begin_test();
        exp_ret(32'h4, 4); exp_ret(32'h8, 8); exp_ret(32'hC, 12); exp_ret(32'h10, 16);
        exp_ret(32'h1C, 20); exp_ret(32'h20, 24); exp_ret(32'h24, 28); exp_ret(32'h28, 32); exp_ret(32'h2C, 36);
        push(Q_HALT, "jal_addi_x2", S_REG, 2, 32'd7);
        push(Q_HALT, "jal_andi_x3", S_REG, 3, 32'd5);
        push(Q_HALT, "jal_ori_x4", S_REG, 4, 32'hB);
        push(Q_HALT, "jal_xori_x5", S_REG, 5, 32'hFFFF_FFFC);
        push(Q_HALT, "jal_addi_f7_x6", S_REG, 6, 32'h403);
        push(Q_HALT, "jal_link_x7", S_REG, 7, 32'h14);
        push(Q_HALT, "jal_x0_read_x8", S_REG, 8, 32'd3);
        exp_halt(32'h2C, 9, 38, 1'b0);
        run_to_halt("jal");

        // Illegal opcode at 0x8: counters frozen 10 cycles into HALT
        prog.delete();
        prog.push_back(i_ins(12'd1, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(i_ins(12'd2, 5'd0, 3'b000, 5'd2, 7'h13));
        prog.push_back(32'h0000_007F);
        begin_test();
        exp_ret(32'h4, 4); exp_ret(32'h8, 8);
        exp_halt(32'h8, 2, 10, 1'b1);
        run_to_halt("illegal");

        // Reset asserted while the second sw sits in MEM: store must not land
        prog.delete();
        prog.push_back(i_ins(12'h040, 5'd0, 3'b000, 5'd1, 7'h13));
        prog.push_back(s_ins(12'd4, 5'd1, 5'd1));
        prog.push_back(i_ins(12'd7, 5'd0, 3'b000, 5'd2, 7'h13));
        prog.push_back(s_ins(12'd4, 5'd2, 5'd1));
        prog.push_back(ECALL);
        begin_test();
        exp_ret(32'h4, 4); exp_ret(32'h8, 8); exp_ret(32'hC, 12);
        #2;
        reset_b = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (retired == 32'd3 && dbg_state == 3'd3) seen = 1'b1;
            end
            if (!seen) begin
                total++; bad++;
                $display("FAIL rstsw_timeout: sw MEM phase not reached, pc=%h state=%0d", dbg_pc, dbg_state);
            end
        end
        #2;
        push(Q_RST, "rstsw_word11", S_MEM, 'h11, 32'h40);
        push(Q_RST, "rstsw_x2", S_REG, 2, 32'd7);
        push(Q_RST, "rstsw_pc", S_PC, 0, 32'h0);
        push(Q_RST, "rstsw_retired", S_RET, 0, 32'd0);
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rstsw_ret_q_empty", 32'(ret_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
